// File: rtl/a2d_chan_sched_pkg.sv
// ============================================================================
// a2d_chan_sched_pkg : shared types for the A2D round-robin channel scheduler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package a2d_chan_sched_pkg;

  // CMD and RD name the strobe actions taken on the IDLE->WAIT1 and GAP->WAIT2
  // transitions; the FSM never dwells in them.
  typedef enum logic [2:0] {
    A2D_IDLE  = 3'd0,
    A2D_CMD   = 3'd1,
    A2D_WAIT1 = 3'd2,
    A2D_GAP   = 3'd3,
    A2D_RD    = 3'd4,
    A2D_WAIT2 = 3'd5
  } a2d_state_t;

  localparam logic [1:0] CHAN_LFT   = 2'd0;
  localparam logic [1:0] CHAN_RGHT  = 2'd1;
  localparam logic [1:0] CHAN_STEER = 2'd2;
  localparam logic [1:0] CHAN_BATT  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/a2d_chan_sched.sv
// ============================================================================
// a2d_chan_sched : round-robin scheduler sharing one A2D SPI master between
//                  the left/right load cells, steer pot and battery channels.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module a2d_chan_sched
  import a2d_chan_sched_pkg::*;
#(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6,
  parameter int         GAP_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic [1:0]  chan_idx,
  output logic        busy,
  output logic        cnv_cmplt
);

  localparam int            GW       = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

  a2d_state_t    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [1:0]    chan_q, chan_d;
  logic [11:0]   lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
  logic          cmplt_q, cmplt_d;
  logic [2:0]    adc_ch;
  logic [15:0]   cmd_word;
  logic          unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    case (chan_q)
      CHAN_LFT:   adc_ch = CH_LFT;
      CHAN_RGHT:  adc_ch = CH_RGHT;
      CHAN_STEER: adc_ch = CH_STEER;
      default:    adc_ch = CH_BATT;
    endcase
  end

  assign cmd_word = {2'b00, adc_ch, 11'h000};

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    chan_d  = chan_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    cmplt_d = 1'b0;
    wrt     = 1'b0;
    case (state_q)
      A2D_IDLE: begin
        if (nxt) begin
          wrt     = 1'b1;
          cmd_d   = cmd_word;
          state_d = A2D_WAIT1;
        end
      end
      A2D_WAIT1: begin
        if (done) begin
          gap_d   = GAP_LOAD;
          state_d = A2D_GAP;
        end
      end
      A2D_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          wrt     = 1'b1;
          cmd_d   = cmd_word;
          state_d = A2D_WAIT2;
        end
      end
      A2D_WAIT2: begin
        if (done) begin
          case (chan_q)
            CHAN_LFT:   lft_d   = rd_data[11:0];
            CHAN_RGHT:  rght_d  = rd_data[11:0];
            CHAN_STEER: steer_d = rd_data[11:0];
            default:    batt_d  = rd_data[11:0];
          endcase
          chan_d  = chan_q + 2'd1;
          cmplt_d = 1'b1;
          state_d = A2D_IDLE;
        end
      end
      default: state_d = A2D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A2D_IDLE;
      gap_q   <= '0;
      cmd_q   <= '0;
      chan_q  <= CHAN_LFT;
      lft_q   <= '0;
      rght_q  <= '0;
      steer_q <= '0;
      batt_q  <= '0;
      cmplt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      chan_q  <= chan_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
      cmplt_q <= cmplt_d;
    end
  end

  // The word is driven combinationally on the strobe clock, then held from cmd_q.
  assign cmd       = wrt ? cmd_word : cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign chan_idx  = chan_q;
  assign busy      = (state_q != A2D_IDLE);
  assign cnv_cmplt = cmplt_q;

endmodule

`default_nettype wire

// File: tb/tb_a2d_chan_sched.sv
// ============================================================================
// tb_a2d_chan_sched : directed self-checking bench for a2d_chan_sched with a
//                     behavioural SPI master / ADC128S responder.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a2d_chan_sched;

  localparam int SPI_LAT = 20;
  // wrt of first transaction to cnv_cmplt visible: 2*(SPI_LAT+1) + GAP_CYC(1) + 2
  localparam int EXP_LAT = 45;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic [1:0]  chan_idx;
  logic        busy;
  logic        cnv_cmplt;

  always #5 clk = ~clk;

  a2d_chan_sched dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .chan_idx  (chan_idx),
    .busy      (busy),
    .cnv_cmplt (cnv_cmplt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Analog inputs as seen by the ADC
  logic [11:0] v_lft, v_rght, v_steer, v_batt;

  function automatic logic [11:0] chan_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return v_lft;
      3'd4:    return v_rght;
      3'd5:    return v_steer;
      3'd6:    return v_batt;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [2:0] idx2ch(input int i);
    case (i)
      0:       return 3'd0;
      1:       return 3'd4;
      2:       return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  // SPI master + ADC: each transaction returns the channel addressed by the previous one
  int          spi_cnt;
  logic        done_q, inj_done;
  logic [15:0] rd_q;
  logic [2:0]  prev_ch, resp_ch;

  assign done    = done_q | inj_done;
  assign rd_data = rd_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cnt <= 0;
      done_q  <= 1'b0;
      rd_q    <= 16'h0;
      prev_ch <= 3'd0;
      resp_ch <= 3'd0;
    end else begin
      done_q <= 1'b0;
      if (wrt) begin
        spi_cnt <= SPI_LAT;
        prev_ch <= cmd[13:11];
        resp_ch <= prev_ch;
      end else if (spi_cnt != 0) begin
        spi_cnt <= spi_cnt - 1;
        if (spi_cnt == 1) begin
          done_q <= 1'b1;
          rd_q   <= {4'hA, chan_val(resp_ch)};
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / monitor
  logic [11:0] exp_reg [4];
  int          exp_idx = 0;
  int          n_cmplt = 0, n_wrt = 0, n_b2b = 0, wrt_in_conv = 0, t_start = 0;
  logic [2:0]  cmd_log [$];

  initial begin
    for (int i = 0; i < 4; i++) exp_reg[i] = 12'h0;
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_reg[i] = 12'h0;
      exp_idx     = 0;
      wrt_in_conv = 0;
    end else begin
      if (cnv_cmplt) begin
        n_cmplt++;
        exp_reg[exp_idx] = chan_val(idx2ch(exp_idx));
        exp_idx = (exp_idx + 1) % 4;
        check("sb_lft",   32'(lft_ld),    32'(exp_reg[0]));
        check("sb_rght",  32'(rght_ld),   32'(exp_reg[1]));
        check("sb_steer", 32'(steer_pot), 32'(exp_reg[2]));
        check("sb_batt",  32'(batt),      32'(exp_reg[3]));
        check("sb_chan_idx", 32'(chan_idx), 32'(exp_idx));
        check("wrt_per_conv", 32'(wrt_in_conv), 32'd2);
        check("latency", 32'(cyc - t_start), 32'(EXP_LAT));
        wrt_in_conv = 0;
      end
      if (wrt) begin
        n_wrt++;
        wrt_in_conv++;
        if (!busy) t_start = cyc;
        if (cnv_cmplt) n_b2b++;
        cmd_log.push_back(cmd[13:11]);
        check("cmd_word", 32'(cmd), 32'({2'b00, idx2ch(exp_idx), 11'h000}));
      end
    end
  end

  task automatic pulse_nxt();
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
  endtask

  task automatic wait_cmplt(input int target);
    int t = 0;
    while (n_cmplt < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("cmplt_timeout", 32'(n_cmplt >= target), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [11:0] exp1 [4];
  logic [2:0]  exp_cmds [8];
  int          c0, w0, b0;
  logic [11:0] s_lft, s_rght, s_steer, s_batt;
  logic [1:0]  s_idx;

  initial begin
    exp1 = '{12'h150, 12'h250, 12'h800, 12'h9C4};
    exp_cmds = '{3'd0, 3'd0, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6};
    rst = 1'b1; nxt = 1'b0; inj_done = 1'b0;
    v_lft = 12'h150; v_rght = 12'h250; v_steer = 12'h800; v_batt = 12'h9C4;

    repeat (3) @(negedge clk);
    check("rst_lft",   32'(lft_ld),    32'd0);
    check("rst_rght",  32'(rght_ld),   32'd0);
    check("rst_steer", 32'(steer_pot), 32'd0);
    check("rst_batt",  32'(batt),      32'd0);
    check("rst_chan",  32'(chan_idx),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_wrt",   32'(wrt),       32'd0);
    check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    check("rst_cmd",   32'(cmd),       32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1/2: one conversion per channel, in order
    for (int i = 0; i < 4; i++) begin
      pulse_nxt();
      check("busy_after_nxt", 32'(busy), 32'd1);
      wait_cmplt(i + 1);
      check("t1_result", 32'(i == 0 ? lft_ld : i == 1 ? rght_ld : i == 2 ? steer_pot : batt),
            32'(exp1[i]));
      repeat (50) @(negedge clk);
    end
    check("t1_chan_wrap", 32'(chan_idx), 32'd0);
    check("t1_cmplt_cnt", 32'(n_cmplt), 32'd4);
    check("t2_wrt_cnt",   32'(n_wrt),   32'd8);
    for (int i = 0; i < 8; i++) check("t2_cmd_ch", 32'(cmd_log[i]), 32'(exp_cmds[i]));

    // 3: nxt held high -> back-to-back conversions, extra requests ignored
    c0 = n_cmplt; w0 = n_wrt; b0 = n_b2b;
    @(negedge clk) nxt = 1'b1;
    repeat (2000) @(negedge clk);
    nxt = 1'b0;
    wait_idle();
    check("t3_conv_cnt", 32'(n_cmplt - c0), 32'd45);
    check("t3_wrt_cnt",  32'(n_wrt - w0),   32'd90);
    check("t3_b2b_cnt",  32'(n_b2b - b0),   32'd44);
    check("t3_chan_idx", 32'(chan_idx),     32'd1);

    // 4: new left value, only lft_ld moves
    v_lft = 12'h3FF;
    for (int i = 0; i < 4; i++) begin
      pulse_nxt();
      wait_cmplt(n_cmplt + 1);
    end
    check("t4_lft",   32'(lft_ld),    32'h3FF);
    check("t4_rght",  32'(rght_ld),   32'h250);
    check("t4_steer", 32'(steer_pot), 32'h800);
    check("t4_batt",  32'(batt),      32'h9C4);
    check("t4_chan",  32'(chan_idx),  32'd1);

    // 5: async reset during WAIT2 of the steer conversion
    v_lft = 12'h150;
    pulse_nxt();
    wait_cmplt(n_cmplt + 1);
    check("t5_pre_chan", 32'(chan_idx), 32'd2);
    w0 = n_wrt;
    pulse_nxt();
    begin
      int t = 0;
      while (n_wrt < w0 + 2 && t < 2000) begin
        @(negedge clk);
        t++;
      end
    end
    check("t5_second_wrt", 32'(n_wrt - w0), 32'd2);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_busy", 32'(busy),     32'd0);
    check("t5_async_chan", 32'(chan_idx), 32'd0);
    @(negedge clk);
    check("t5_lft",   32'(lft_ld),    32'd0);
    check("t5_rght",  32'(rght_ld),   32'd0);
    check("t5_steer", 32'(steer_pot), 32'd0);
    check("t5_batt",  32'(batt),      32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    w0 = n_wrt;
    pulse_nxt();
    wait_cmplt(n_cmplt + 1);
    check("t5_post_wrt", 32'(n_wrt - w0), 32'd2);
    check("t5_post_lft", 32'(lft_ld), 32'h150);
    check("t5_post_chan", 32'(chan_idx), 32'd1);

    // 6: spurious done while idle
    repeat (5) @(negedge clk);
    s_lft = lft_ld; s_rght = rght_ld; s_steer = steer_pot; s_batt = batt; s_idx = chan_idx;
    c0 = n_cmplt;
    @(negedge clk) inj_done = 1'b1;
    @(negedge clk) inj_done = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_cmplt",  32'(n_cmplt - c0), 32'd0);
    check("t6_busy",   32'(busy),      32'd0);
    check("t6_chan",   32'(chan_idx),  32'(s_idx));
    check("t6_lft",    32'(lft_ld),    32'(s_lft));
    check("t6_rght",   32'(rght_ld),   32'(s_rght));
    check("t6_steer",  32'(steer_pot), 32'(s_steer));
    check("t6_batt",   32'(batt),      32'(s_batt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
